// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end for the MEM stage.
// Accepts one byte/halfword/word load or store per request and drives a
// word-only, big-endian RAM. Sub-word stores are read-modify-write. Loads
// are returned sign- or zero-extended.
// Ports:
//   clk, rst (sync, active-low)
//   req_valid/req_ready/req_op/req_addr/req_wdata : request channel
//   resp_valid/resp_rdata/resp_err                : one-cycle response
//   mem_ce/mem_we/mem_addr/mem_wdata/mem_rdata    : RAM port
module mem_access_unit #(
  parameter  int unsigned ADDR_W = 32,
  localparam int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              state, state_next;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   word_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                req_legal;
  logic                req_misaligned;
  logic                req_bad;
  logic                accept;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   load_ext;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [ADDR_W-1:0]   word_addr;

  // Request legality: op code and natural alignment of the access size.
  always_comb begin
    req_legal = 1'b0;
    case (req_op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: req_legal = 1'b1;
      default: req_legal = 1'b0;
    endcase
  end

  assign req_misaligned = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_bad   = !req_legal || req_misaligned;
  assign accept    = req_valid && req_ready;
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Big-endian lane select of the RAM read word, then extension.
  always_comb begin
    lane_b = 8'h00;
    case (addr_q[1:0])
      2'd0:    lane_b = mem_rdata[31:24];
      2'd1:    lane_b = mem_rdata[23:16];
      2'd2:    lane_b = mem_rdata[15:8];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (op_q[1:0])
      2'b00:   load_ext = op_q[2] ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = op_q[2] ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // Store word: the read-back word with the addressed lane replaced, or the full word for SW.
  always_comb begin
    merged = word_q;
    case (op_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merged[31:24] = wdata_q[7:0];
          2'd1:    merged[23:16] = wdata_q[7:0];
          2'd2:    merged[15:8]  = wdata_q[7:0];
          default: merged[7:0]   = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[15:0]  = wdata_q[15:0];
        else           merged[31:16] = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // Next state and RAM/handshake outputs; ce/we are gated by rst so a reset edge never writes.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)            state_next = RESP;
          else if (req_op == OP_SW) state_next = WR;
          else                    state_next = RD;
        end
      end
      RD: begin
        mem_ce     = rst;
        mem_addr   = word_addr;
        state_next = op_q[3] ? WR : RESP;
      end
      WR: begin
        mem_ce     = rst;
        mem_we     = rst;
        mem_addr   = word_addr;
        mem_wdata  = merged;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Request capture, RAM read word and load result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_bad;
      end
      if (state == RD) begin
        word_q <= mem_rdata;
        if (!op_q[3]) rdata_q <= load_ext;
      end
    end
  end

  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small word RAM model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:63];

  int n_err;
  int n_checks;

  int          rc, nr, nwe, nce;
  logic        re, r0, r1;
  logic [31:0] rd;
  logic [31:0] last_load;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM read port; a junk pattern stands in for high-Z when not reading.
  assign mem_rdata = (mem_ce && !mem_we) ? ram[mem_addr[7:2]] : 32'hA5A5A5A5;

  // Issue one request and observe cycles 1..6 after the accept edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output int rcyc, output int nresp, output logic rerr, output logic [31:0] rdat,
                        output int nw, output int nc, output logic rdy0, output logic rdy1);
    rcyc = 0; nresp = 0; rerr = 1'b0; rdat = 32'h0; nw = 0; nc = 0; rdy1 = 1'b1;
    @(negedge clk);
    rdy0      = req_ready;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 4'hF;
    req_addr  = 32'hFFFFFFFF;
    req_wdata = 32'hFFFFFFFF;
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) rdy1 = req_ready;
      if (mem_ce) nc++;
      if (mem_ce && mem_we) begin
        nw++;
        ram[mem_addr[7:2]] = mem_wdata;
      end
      if (resp_valid) begin
        nresp++;
        if (rcyc == 0) rcyc = c;
        rerr = resp_err;
        rdat = resp_rdata;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_resp_rdata got %h exp 0", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
    n_checks++; if ({mem_ce, mem_we} !== 2'b00) begin n_err++; $display("FAIL reset_mem_ce_we got %b exp 00", {mem_ce, mem_we}); end
    n_checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin n_err++; $display("FAIL reset_mem_addr_wdata got %h exp 0", {mem_addr, mem_wdata}); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_lw();
    ram[4] = 32'h11223344;
    run_op(4'b0010, 32'h10, 32'h0, rc, nr, re, rd, nwe, nce, r0, r1);
    n_checks++; if (r0 !== 1'b1) begin n_err++; $display("FAIL lw_ready_idle got %b exp 1", r0); end
    n_checks++; if (r1 !== 1'b0) begin n_err++; $display("FAIL lw_ready_busy got %b exp 0", r1); end
    n_checks++; if (rc !== 2 || nr !== 1) begin n_err++; $display("FAIL lw_resp_cycle got %0d/%0d exp 2/1", rc, nr); end
    n_checks++; if (rd !== 32'h11223344) begin n_err++; $display("FAIL lw_rdata got %h exp 11223344", rd); end
    n_checks++; if (re !== 1'b0) begin n_err++; $display("FAIL lw_err got %b exp 0", re); end
    n_checks++; if (nce !== 1 || nwe !== 0) begin n_err++; $display("FAIL lw_mem_cycles ce=%0d we=%0d exp 1/0", nce, nwe); end
    last_load = 32'h11223344;
  endtask

  task automatic test_extension();
    logic [3:0]  ops  [0:7];
    logic [31:0] adrs [0:7];
    logic [31:0] exps [0:7];
    ram[8] = 32'h80FF0000;
    ram[9] = 32'h7F128034;
    ops[0] = 4'b0000; adrs[0] = 32'h21; exps[0] = 32'hFFFFFFFF;
    ops[1] = 4'b0100; adrs[1] = 32'h21; exps[1] = 32'h000000FF;
    ops[2] = 4'b0001; adrs[2] = 32'h20; exps[2] = 32'hFFFF80FF;
    ops[3] = 4'b0101; adrs[3] = 32'h20; exps[3] = 32'h000080FF;
    ops[4] = 4'b0000; adrs[4] = 32'h24; exps[4] = 32'h0000007F;
    ops[5] = 4'b0000; adrs[5] = 32'h27; exps[5] = 32'h00000034;
    ops[6] = 4'b0001; adrs[6] = 32'h26; exps[6] = 32'hFFFF8034;
    ops[7] = 4'b0101; adrs[7] = 32'h22; exps[7] = 32'h00000000;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], adrs[i], 32'h0, rc, nr, re, rd, nwe, nce, r0, r1);
      n_checks++;
      if (rd !== exps[i] || rc !== 2 || re !== 1'b0) begin
        n_err++;
        $display("FAIL ext_%0d op=%b addr=%h got %h cyc=%0d err=%b exp %h cyc=2 err=0", i, ops[i], adrs[i], rd, rc, re, exps[i]);
      end
    end
    last_load = exps[7];
  endtask

  task automatic test_sb();
    ram[4] = 32'h11223344;
    run_op(4'b1000, 32'h11, 32'hAABBCCDD, rc, nr, re, rd, nwe, nce, r0, r1);
    n_checks++; if (ram[4] !== 32'h11DD3344) begin n_err++; $display("FAIL sb_word got %h exp 11DD3344", ram[4]); end
    n_checks++; if (rc !== 3 || nr !== 1) begin n_err++; $display("FAIL sb_resp_cycle got %0d/%0d exp 3/1", rc, nr); end
    n_checks++; if (nwe !== 1 || nce !== 2) begin n_err++; $display("FAIL sb_mem_cycles we=%0d ce=%0d exp 1/2", nwe, nce); end
    n_checks++; if (rd !== last_load || re !== 1'b0) begin n_err++; $display("FAIL sb_rdata_hold got %h err=%b exp %h err=0", rd, re, last_load); end
    run_op(4'b1000, 32'h13, 32'h12345677, rc, nr, re, rd, nwe, nce, r0, r1);
    n_checks++; if (ram[4] !== 32'h11DD3377) begin n_err++; $display("FAIL sb_lane3 got %h exp 11DD3377", ram[4]); end
    run_op(4'b1000, 32'h10, 32'h000000EE, rc, nr, re, rd, nwe, nce, r0, r1);
    n_checks++; if (ram[4] !== 32'hEEDD3377) begin n_err++; $display("FAIL sb_lane0 got %h exp EEDD3377", ram[4]); end
  endtask

  task automatic test_sh_then_lw();
    ram[4] = 32'h11223344;
    run_op(4'b1001, 32'h12, 32'h0000BEEF, rc, nr, re, rd, nwe, nce, r0, r1);
    n_checks++; if (rc !== 3 || nwe !== 1) begin n_err++; $display("FAIL sh_timing cyc=%0d we=%0d exp 3/1", rc, nwe); end
    run_op(4'b0010, 32'h10, 32'h0, rc, nr, re, rd, nwe, nce, r0, r1);
    n_checks++; if (rd !== 32'h1122BEEF) begin n_err++; $display("FAIL sh_lw_readback got %h exp 1122BEEF", rd); end
    run_op(4'b1001, 32'h10, 32'h1234CAFE, rc, nr, re, rd, nwe, nce, r0, r1);
    n_checks++; if (ram[4] !== 32'hCAFEBEEF) begin n_err++; $display("FAIL sh_upper got %h exp CAFEBEEF", ram[4]); end
    last_load = 32'h1122BEEF;
  endtask

  task automatic test_sw();
    ram[5] = 32'h0;
    run_op(4'b1010, 32'h14, 32'hDEADBEEF, rc, nr, re, rd, nwe, nce, r0, r1);
    n_checks++; if (ram[5] !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_word got %h exp DEADBEEF", ram[5]); end
    n_checks++; if (rc !== 2 || nwe !== 1 || nce !== 1) begin n_err++; $display("FAIL sw_timing cyc=%0d we=%0d ce=%0d exp 2/1/1", rc, nwe, nce); end
  endtask

  task automatic test_errors();
    logic [3:0]  ops  [0:4];
    logic [31:0] adrs [0:4];
    ops[0] = 4'b0010; adrs[0] = 32'h12;
    ops[1] = 4'b0011; adrs[1] = 32'h10;
    ops[2] = 4'b1001; adrs[2] = 32'h11;
    ops[3] = 4'b1010; adrs[3] = 32'h16;
    ops[4] = 4'b1100; adrs[4] = 32'h10;
    ram[4] = 32'h55667788;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], adrs[i], 32'h01020304, rc, nr, re, rd, nwe, nce, r0, r1);
      n_checks++;
      if (rc !== 1 || nr !== 1 || re !== 1'b1 || nce !== 0 || rd !== last_load) begin
        n_err++;
        $display("FAIL err_%0d op=%b got cyc=%0d n=%0d err=%b ce=%0d rdata=%h exp 1/1/1/0/%h", i, ops[i], rc, nr, re, nce, rd, last_load);
      end
    end
    n_checks++; if (ram[4] !== 32'h55667788) begin n_err++; $display("FAIL err_ram_touched got %h exp 55667788", ram[4]); end
  endtask

  task automatic test_reset_during_wr();
    int nw_after, nr_after;
    logic rdy_after;
    ram[4] = 32'h11223344;
    nw_after = 0; nr_after = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b1000; req_addr = 32'h11; req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if ({mem_ce, mem_we} !== 2'b00) begin n_err++; $display("FAIL rst_wr_gating got %b exp 00", {mem_ce, mem_we}); end
    if (mem_ce && mem_we) ram[mem_addr[7:2]] = mem_wdata;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_after = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) nr_after++;
      if (mem_ce && mem_we) begin nw_after++; ram[mem_addr[7:2]] = mem_wdata; end
      if (c == 1) rdy_after = req_ready;
      @(posedge clk);
      #1;
    end
    n_checks++; if (nr_after !== 0 || nw_after !== 0) begin n_err++; $display("FAIL rst_wr_activity resp=%0d we=%0d exp 0/0", nr_after, nw_after); end
    n_checks++; if (rdy_after !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready got %b exp 1", rdy_after); end
    n_checks++; if (ram[4] !== 32'h11223344) begin n_err++; $display("FAIL rst_wr_word got %h exp 11223344", ram[4]); end
    run_op(4'b0010, 32'h10, 32'h0, rc, nr, re, rd, nwe, nce, r0, r1);
    n_checks++; if (rd !== 32'h11223344 || rc !== 2) begin n_err++; $display("FAIL rst_wr_recover got %h cyc=%0d exp 11223344 cyc=2", rd, rc); end
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    last_load = 32'h0;
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    test_reset();
    test_lw();
    test_extension();
    test_sb();
    test_sh_then_lw();
    test_sw();
    test_errors();
    test_reset_during_wr();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front-end for the MEM stage of the pipeline. It accepts one byte/halfword/word load or store per request and drives the word-only, big-endian data RAM through its `ce`/`we`/`addr`/`wtData`/`rdData` port set. Sub-word stores are performed as a read-modify-write. Loads are returned to the writeback stage with sign or zero extension applied.

## Interface
- `ADDR_W`, default 32: byte-address width; equals `LEN_ADDR_RAM`.
- `DATA_W`, fixed 32: data width; equals `LEN_DATA_RAM`.

Ports:
- `clk`, input, 1: single clock. All state updates on posedge.
- `rst`, input, 1: reset, synchronous, active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: unit can accept a request; 1 only in IDLE.
- `req_op`, input, 4: operation. LB=0000, LH=0001, LW=0010, LBU=0100, LHU=0101, SB=1000, SH=1001, SW=1010. Any other code is illegal.
- `req_addr`, input, ADDR_W: byte address.
- `req_wdata`, input, 32: store data. Bytes/halfwords are taken from the low bits.
- `resp_valid`, output, 1: one-cycle completion pulse. There is no backpressure on responses.
- `resp_rdata`, output, 32: extended load data. Holds its value until the next load response.
- `resp_err`, output, 1: misaligned or illegal op. Valid with `resp_valid`.
- `mem_ce`, output, 1: RAM chip enable.
- `mem_we`, output, 1: RAM write enable.
- `mem_addr`, output, ADDR_W: word-aligned RAM address.
- `mem_wdata`, output, 32: RAM write data.
- `mem_rdata`, input, 32: RAM combinational read data. It is high-Z when the RAM is not reading.

## Operation
- **States:** IDLE, RD, WR, RESP.
- **Request capture:** on `req_valid && req_ready`, latch op, addr, wdata. Then go to:
  - RESP with err=1 if the op is illegal, or if LH/LHU/SH has `addr[0]`≠0, or if LW/SW has `addr[1:0]`≠0;
  - else RD for loads and SB/SH;
  - else WR for SW.
- **RD:**
  - Drive `mem_ce`=1, `mem_we`=0, `mem_addr`={addr[ADDR_W-1:2],2'b00}.
  - Register `mem_rdata` into `word_q` at the clock edge.
  - Loads go to RESP; SB/SH go to WR.
- **WR:**
  - Drive `mem_ce`=1, `mem_we`=1, same `mem_addr`.
  - `mem_wdata` is `req_wdata` for SW. For SB/SH it is `word_q` with the addressed lane replaced.
  - Go to RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle, then return to IDLE. `resp_rdata` updates only for non-error loads.
- **Lane mapping (big-endian):** byte offset k occupies `word[31-8k -: 8]`. Halfword offset 0 is `[31:16]`; offset 2 is `[15:0]`.
- **Load extension:** LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes the word through.
- **Outputs when not in RD/WR:** `mem_ce`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. `mem_rdata` is ignored outside RD.
- **Reset gating:** `mem_ce` and `mem_we` are gated combinationally by `rst`. While `rst`=0 both are 0, so no RAM write occurs on a reset edge even if the state is WR.
- **Reset values:**
  - state=IDLE, `req_ready`=1 (after the reset cycle), `resp_valid`=0, `resp_rdata`=0, `resp_err`=0;
  - `word_q`=0, latched request fields = 0;
  - all `mem_*` outputs = 0.
- **Reset mid-operation:** abandon the operation and produce no response. A partially completed sub-word store writes nothing.

## Timing
Cycle 0 is the accept edge.
- **Load:** RD in cycle 1; `resp_valid` in cycle 2.
- **SW:** WR in cycle 1, with the RAM write at the end of cycle 1; `resp_valid` in cycle 2.
- **SB/SH:** RD in cycle 1, WR in cycle 2; `resp_valid` in cycle 3.
- **Error:** `resp_valid`+`resp_err` in cycle 1; `mem_ce` is never asserted.
- **Throughput:** the next request is accepted no earlier than the cycle after RESP.
- **Request hold:** `req_*` need only be valid on the accept edge.

## Test plan
- **LW:** RAM[0x10..0x13] = 11 22 33 44. LW 0x10 → `resp_valid` at cycle 2, `resp_rdata`=0x11223344, `resp_err`=0.
- **Extension:** word at 0x20 = 0x80FF0000.
  - LB 0x21 → 0xFFFFFFFF.
  - LBU 0x21 → 0x000000FF.
  - LH 0x20 → 0xFFFF80FF.
  - LHU 0x20 → 0x000080FF.
- **SB:** SB 0x11 with wdata 0xAABBCCDD onto 0x11223344 → word 0x11DD3344. `resp_valid` at cycle 3; exactly one `mem_we` cycle.
- **SH then LW:** SH 0x12 with wdata 0x0000BEEF → a subsequent LW 0x10 returns 0x1122BEEF.
- **Errors:**
  - LW 0x12 → `resp_valid`=`resp_err`=1 at cycle 1, `mem_ce`=0 throughout, `resp_rdata` unchanged.
  - `req_op`=0011 behaves the same way.
- **Reset during WR:** SB 0x11 with `rst`=0 held during the WR cycle → RAM word unchanged, no `resp_valid`. `req_ready`=1 the cycle after `rst` returns to 1.
